// File: rtl/noc_flit_receiver.sv
// noc_flit_receiver: terminal consumer for one NoC router output port.
// Buffers accepted flits in a first-word-fall-through FIFO, reports
// full/almost_full back to the router, and checks each flit's destination
// and per-source sequence number. Errors are held in sticky flags.
// Optional build macro NOC_RX_STATS_EN adds per-source accepted-flit
// counters on the src_count output.
module noc_flit_receiver #(
    parameter int         DEPTH      = 8,
    parameter logic [3:0] LOCAL_ADDR = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [15:0] dataIn,
    output logic        full,
    output logic        almost_full,
    input  logic        pop,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [15:0] rx_count,
    output logic        seq_err,
    output logic        dest_err,
    output logic        ovf_err,
    input  logic        clear_err
`ifdef NOC_RX_STATS_EN
    ,
    output logic [31:0] src_count
`endif
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    OCC_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]    OCC_AFULL = (AW+1)'(DEPTH - 1);

    typedef enum logic {UNSEEN, TRACKING} trk_t;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   occ_q, occ_d, occ_rem;
    logic [15:0]   head_q, head_d;
    logic [15:0]   rxc_q;
    logic          seq_err_q, dest_err_q, ovf_err_q;
    trk_t          st_q [4];
    trk_t          st_d [4];
    logic [8:0]    exp_q [4];
    logic [8:0]    exp_d [4];

    logic          push_ok, pop_ok, ovf_hit, dest_hit, seq_hit;
    logic [1:0]    src;
    logic [8:0]    seq;

    assign src = dataIn[6:5];
    assign seq = dataIn[15:7];

    // Flow-control flags come only from the occupancy register.
    assign full        = (occ_q == OCC_FULL);
    assign almost_full = (occ_q >= OCC_AFULL);
    assign out_valid   = (occ_q != '0);

    assign push_ok  = write & dataIn[0] & ~full;
    assign ovf_hit  = write & dataIn[0] & full;
    assign pop_ok   = pop & out_valid;
    assign dest_hit = push_ok & (dataIn[4:1] != LOCAL_ADDR);

    // FIFO pointer/occupancy next state and the registered head flit.
    always_comb begin
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop_ok);
        occ_d   = occ_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        occ_rem = occ_q - (AW+1)'(pop_ok);
        head_d  = head_q;
        if (occ_rem != '0)
            head_d = mem_q[rptr_d];
        else if (push_ok)
            head_d = dataIn;
    end

    // Flit storage carries no reset; only entries below occupancy are read.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= dataIn;
    end

    // FIFO control, counter and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            head_q     <= '0;
            rxc_q      <= '0;
            seq_err_q  <= 1'b0;
            dest_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            rxc_q      <= rxc_q + 16'(push_ok);
            seq_err_q  <= (seq_err_q  & ~clear_err) | seq_hit;
            dest_err_q <= (dest_err_q & ~clear_err) | dest_hit;
            ovf_err_q  <= (ovf_err_q  & ~clear_err) | ovf_hit;
        end
    end

    // Sequence tracker state register, one per source id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                st_q[k]  <= UNSEEN;
                exp_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                st_q[k]  <= st_d[k];
                exp_q[k] <= exp_d[k];
            end
        end
    end

    // Sequence tracker next state: any accepted flit resyncs its source.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            st_d[k]  = st_q[k];
            exp_d[k] = exp_q[k];
        end
        if (push_ok) begin
            st_d[src]  = TRACKING;
            exp_d[src] = seq + 9'd1;
        end
    end

    // Sequence tracker output: mismatch only while already tracking.
    always_comb begin
        seq_hit = 1'b0;
        if (push_ok && (st_q[src] == TRACKING) && (seq != exp_q[src]))
            seq_hit = 1'b1;
    end

`ifdef NOC_RX_STATS_EN
    logic [7:0] scnt_q [4];

    // Per-source accepted counters; clear wins over the old value, not the new flit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++)
                scnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (clear_err)
                    scnt_q[k] <= {7'd0, push_ok && (src == 2'(k))};
                else
                    scnt_q[k] <= scnt_q[k] + 8'(push_ok && (src == 2'(k)));
            end
        end
    end

    assign src_count = {scnt_q[3], scnt_q[2], scnt_q[1], scnt_q[0]};
`endif

    assign out_data = head_q;
    assign rx_count = rxc_q;
    assign seq_err  = seq_err_q;
    assign dest_err = dest_err_q;
    assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_noc_flit_receiver.sv
// Scoreboard bench for noc_flit_receiver (DEPTH=8, LOCAL_ADDR=0).
module tb_noc_flit_receiver;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, write, pop, clear_err;
    logic [15:0] dataIn;
    logic        full, almost_full, out_valid, seq_err, dest_err, ovf_err;
    logic [15:0] out_data, rx_count;
`ifdef NOC_RX_STATS_EN
    logic [31:0] src_count;
`endif

    noc_flit_receiver #(.DEPTH(DEPTH), .LOCAL_ADDR(4'h0)) dut (
        .clk(clk), .reset(reset), .write(write), .dataIn(dataIn),
        .full(full), .almost_full(almost_full), .pop(pop),
        .out_valid(out_valid), .out_data(out_data), .rx_count(rx_count),
        .seq_err(seq_err), .dest_err(dest_err), .ovf_err(ovf_err),
        .clear_err(clear_err)
`ifdef NOC_RX_STATS_EN
        , .src_count(src_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [15:0] sb[$];
    int          m_occ, m_rx;
    bit          m_seq, m_dest, m_ovf;
    bit          m_seen[4];
    int          m_exp[4];
    int          m_scnt[4];
    logic [15:0] m_head;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_occ = 0; m_rx = 0; m_seq = 0; m_dest = 0; m_ovf = 0; m_head = 16'h0;
        for (int k = 0; k < 4; k++) begin
            m_seen[k] = 0; m_exp[k] = 0; m_scnt[k] = 0;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".occ_valid"}, {31'd0, out_valid}, {31'd0, m_occ > 0});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, m_occ == DEPTH});
        chk({tag, ".afull"}, {31'd0, almost_full}, {31'd0, m_occ >= DEPTH - 1});
        chk({tag, ".out_data"}, {16'd0, out_data}, {16'd0, m_head});
        chk({tag, ".rx_count"}, {16'd0, rx_count}, 32'(m_rx & 16'hFFFF));
        chk({tag, ".seq_err"}, {31'd0, seq_err}, {31'd0, m_seq});
        chk({tag, ".dest_err"}, {31'd0, dest_err}, {31'd0, m_dest});
        chk({tag, ".ovf_err"}, {31'd0, ovf_err}, {31'd0, m_ovf});
`ifdef NOC_RX_STATS_EN
        for (int k = 0; k < 4; k++)
            chk({tag, ".src_count"}, {24'd0, src_count[8*k +: 8]}, 32'(m_scnt[k]));
`endif
    endtask

    // One clock: drive at posedge+2, predict, then check at the next posedge+1.
    task automatic cyc(input bit w, input logic [15:0] d, input bit p, input bit clr, input string tag);
        bit acc, ovf, pk, seqbad;
        int s, q;
        write = w; dataIn = d; pop = p; clear_err = clr;
        acc = w && d[0] && (m_occ < DEPTH);
        ovf = w && d[0] && (m_occ == DEPTH);
        pk  = p && (m_occ > 0);
        s = int'(d[6:5]);
        q = int'(d[15:7]);
        seqbad = 0;
        if (acc) begin
            sb.push_back(d);
            m_rx++;
            if (m_seen[s] && q != m_exp[s]) seqbad = 1;
            m_seen[s] = 1;
            m_exp[s]  = (q + 1) % 512;
        end
        for (int k = 0; k < 4; k++) begin
            if (clr) m_scnt[k] = (acc && s == k) ? 1 : 0;
            else if (acc && s == k) m_scnt[k] = (m_scnt[k] + 1) % 256;
        end
        m_seq  = (m_seq  && !clr) || seqbad;
        m_dest = (m_dest && !clr) || (acc && d[4:1] != 4'h0);
        m_ovf  = (m_ovf  && !clr) || ovf;
        m_occ  = m_occ + (acc ? 1 : 0) - (pk ? 1 : 0);
        @(posedge clk);
        #1;
        if (m_occ > 0 && sb.size() > 0) m_head = sb[0];
        check_state(tag);
        #1;
    endtask

    function automatic logic [15:0] flit(input int sq, input int s, input int dst);
        return {9'(sq), 2'(s), 4'(dst), 1'b1};
    endfunction

    // Monitor: every transfer the DUT presents is popped from the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && out_valid === 1'b1 && pop === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL mon.unexpected: got %h expected none", out_data);
                end else begin
                    chk("mon.data", {16'd0, out_data}, {16'd0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        int rs, rq, guard;
        logic [15:0] f;
        reset = 1'b1; write = 0; pop = 0; clear_err = 0; dataIn = '0;
        model_reset();
        @(posedge clk); #2;
        check_state("reset");
        reset = 1'b0;

        // Three in-order flits from src 2.
        cyc(1, 16'h0041, 0, 0, "w0");
        cyc(1, 16'h00C1, 0, 0, "w1");
        cyc(1, 16'h0141, 0, 0, "w2");
        // Fill to full, then overflow.
        for (int i = 3; i < 9; i++) cyc(1, flit(i, 2, 0), 0, 0, "fill");
        // Invalid-bit write while full: no effect.
        cyc(1, 16'h0040, 0, 0, "inval");
        cyc(0, 16'h0, 0, 1, "clr");
        for (int i = 0; i < 8; i++) cyc(0, 16'h0, 1, 0, "drain");
        cyc(0, 16'h0, 1, 0, "pop_empty");

        // Sequence error on src 0, then clear and in-order follow-up.
        cyc(1, 16'h0001, 1, 0, "s0a");
        cyc(1, 16'h0101, 1, 0, "s0b");
        cyc(0, 16'h0, 1, 1, "clr2");
        cyc(1, 16'h0181, 1, 0, "s0c");
        // Misrouted flit is stored and flagged.
        cyc(1, 16'h0017, 0, 0, "dest");
        cyc(0, 16'h0, 1, 1, "clr3");

        // Streaming push+pop with sequence wrap on src 1.
        for (int i = 0; i < 600; i++) cyc(1, flit(i % 512, 1, 0), 1, 0, "stream");

        // Random traffic, mostly in-order, occasional errors and clears.
        for (int i = 0; i < 400; i++) begin
            rs = $urandom_range(0, 3);
            rq = ($urandom_range(0, 5) == 0 || !m_seen[rs]) ? int'($urandom_range(0, 511)) : m_exp[rs];
            f  = flit(rq, rs, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 0);
            if ($urandom_range(0, 9) == 0) f[0] = 1'b0;
            cyc($urandom_range(0, 3) != 0, f, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, "rand");
        end

        // Drain, buffer five flits, then reset mid-operation.
        guard = 0;
        while (m_occ > 0 && guard < 20) begin
            cyc(0, 16'h0, 1, 0, "drain2");
            guard++;
        end
        chk("drain2.bound", 32'(m_occ), 32'd0);
        for (int i = 0; i < 5; i++) cyc(1, flit(i + 40, 3, 0), 0, 0, "pre_rst");
        cyc(1, 16'h0103, 0, 0, "mk_err");
        reset = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        @(posedge clk); #2;
        reset = 1'b0;
        cyc(1, flit(300, 3, 0), 0, 0, "unseen3");
        cyc(1, flit(77, 2, 0), 0, 0, "unseen2");
        cyc(1, flit(301, 3, 0), 1, 0, "track3");
        cyc(0, 16'h0, 1, 0, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
